// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: bus widths, the packed
// stage bundle and the skid-buffer state encoding.
package ysyx_23060251_pkg;

  localparam int REG_BUS  = 32;
  localparam int RS_BUS   = 5;
  localparam int MASK_BUS = 8;
  localparam int SYS_BUS  = 4;

  typedef struct packed {
    logic [REG_BUS-1:0]  alu_result;
    logic [REG_BUS-1:0]  csr_wdata;
    logic [REG_BUS-1:0]  src2;
    logic [RS_BUS-1:0]   rd;
    logic                wen_reg;
    logic                wen_csr;
    logic                wen_mem;
    logic                ren_mem;
    logic                is_load_signed;
    logic [MASK_BUS-1:0] mask;
    logic [SYS_BUS-1:0]  sys_info;
  } ex_mem_bundle_t;

  localparam int BUNDLE_W = $bits(ex_mem_bundle_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ex_mem_if.sv
// Valid/ready/data channel used on both sides of the skid buffer.
interface ex_mem_if
  import ysyx_23060251_pkg::*;
#(
  parameter int DATA_WIDTH = BUNDLE_W
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ex_mem_skid_buf.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one
// extra bundle so ready never depends combinationally on downstream ready.
module skid_buf
  import ysyx_23060251_pkg::*;
#(
  parameter int DATA_WIDTH = BUNDLE_W
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  ex_mem_if.slave  up_port,
  ex_mem_if.master dn_port
);

  skid_state_t           state_r;
  logic [DATA_WIDTH-1:0] main_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  ready_r;
  logic                  valid_r;
  logic                  accept_s;
  logic                  deliver_s;

  assign accept_s      = up_port.valid & ready_r;
  assign deliver_s     = valid_r & dn_port.ready;
  assign up_port.ready = ready_r;
  assign dn_port.valid = valid_r;
  assign dn_port.data  = main_r;

  // State, handshake flags and entries; flush empties without touching data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      main_r  <= '0;
      skid_r  <= '0;
    end else if (flush_i) begin
      state_r <= EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_r  <= up_port.data;
            state_r <= ONE;
            valid_r <= 1'b1;
            ready_r <= 1'b1;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (accept_s && !deliver_s) begin
            skid_r  <= up_port.data;
            state_r <= TWO;
            ready_r <= 1'b0;
          end else if (accept_s && deliver_s) begin
            main_r  <= up_port.data;
          end else if (deliver_s) begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
          end else begin
            state_r <= ONE;
          end
        end
        TWO: begin
          // Skid is always younger than main, so it moves up on delivery.
          if (deliver_s) begin
            main_r  <= skid_r;
            state_r <= ONE;
            ready_r <= 1'b1;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          state_r <= EMPTY;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: packs the EXU outputs into one bundle, buffers it
// in a skid buffer and presents it to MEM with enables gated by valid.
module ex_mem
  import ysyx_23060251_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REG_BUS-1:0]  e_alu_result_i,
  input  logic [REG_BUS-1:0]  e_csr_wdata_i,
  input  logic [REG_BUS-1:0]  e_src2_i,
  input  logic [RS_BUS-1:0]   e_rd_i,
  input  logic                e_wenReg_i,
  input  logic                e_wenCsr_i,
  input  logic                e_wenMem_i,
  input  logic                e_renMem_i,
  input  logic                e_is_load_signed_i,
  input  logic [MASK_BUS-1:0] e_mask_i,
  input  logic [SYS_BUS-1:0]  e_sys_info_i,
  input  logic                e_valid_i,
  output logic                M_ready_o,
  output logic [REG_BUS-1:0]  m_alu_result_o,
  output logic [REG_BUS-1:0]  m_csr_wdata_o,
  output logic [REG_BUS-1:0]  m_src2_o,
  output logic [RS_BUS-1:0]   m_rd_o,
  output logic                m_wenReg_o,
  output logic                m_wenCsr_o,
  output logic                m_wenMem_o,
  output logic                m_renMem_o,
  output logic                m_is_load_signed_o,
  output logic [MASK_BUS-1:0] m_mask_o,
  output logic [SYS_BUS-1:0]  m_sys_info_o,
  output logic                M_valid_o,
  input  logic                m_ready_i,
  input  logic                flush_i
);

  ex_mem_bundle_t in_s;
  ex_mem_bundle_t out_s;

  ex_mem_if #(.DATA_WIDTH(BUNDLE_W)) up_if ();
  ex_mem_if #(.DATA_WIDTH(BUNDLE_W)) dn_if ();

  // Pack the EXU fields into one atomic bundle.
  always_comb begin
    in_s                = '0;
    in_s.alu_result     = e_alu_result_i;
    in_s.csr_wdata      = e_csr_wdata_i;
    in_s.src2           = e_src2_i;
    in_s.rd             = e_rd_i;
    in_s.wen_reg        = e_wenReg_i;
    in_s.wen_csr        = e_wenCsr_i;
    in_s.wen_mem        = e_wenMem_i;
    in_s.ren_mem        = e_renMem_i;
    in_s.is_load_signed = e_is_load_signed_i;
    in_s.mask           = e_mask_i;
    in_s.sys_info       = e_sys_info_i;
  end

  assign up_if.valid = e_valid_i;
  assign up_if.data  = in_s;
  assign M_ready_o   = up_if.ready;
  assign dn_if.ready = m_ready_i;
  assign M_valid_o   = dn_if.valid;
  assign out_s       = ex_mem_bundle_t'(dn_if.data);

  skid_buf #(.DATA_WIDTH(BUNDLE_W)) u_skid_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .up_port (up_if),
    .dn_port (dn_if)
  );

  assign m_alu_result_o     = out_s.alu_result;
  assign m_csr_wdata_o      = out_s.csr_wdata;
  assign m_src2_o           = out_s.src2;
  assign m_rd_o             = out_s.rd;
  assign m_is_load_signed_o = out_s.is_load_signed;
  assign m_mask_o           = out_s.mask;
  assign m_sys_info_o       = out_s.sys_info;
  // Stale data is harmless downstream as long as no side-effect enable leaks.
  assign m_wenReg_o         = out_s.wen_reg & dn_if.valid;
  assign m_wenCsr_o         = out_s.wen_csr & dn_if.valid;
  assign m_wenMem_o         = out_s.wen_mem & dn_if.valid;
  assign m_renMem_o         = out_s.ren_mem & dn_if.valid;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: a queue-based reference (at most two bundles in flight),
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem;
  import ysyx_23060251_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  logic m_ready;
  int   n_tests;
  int   n_fail;
  logic chk_en;

  ex_mem_if #(.DATA_WIDTH(BUNDLE_W)) tb_if ();
  ex_mem_bundle_t in_view;
  assign in_view = ex_mem_bundle_t'(tb_if.data);

  logic [REG_BUS-1:0]  m_alu, m_csr, m_src2;
  logic [RS_BUS-1:0]   m_rd;
  logic                m_wen_reg, m_wen_csr, m_wen_mem, m_ren_mem, m_lsig;
  logic [MASK_BUS-1:0] m_mask;
  logic [SYS_BUS-1:0]  m_sys;
  logic                m_valid;

  ex_mem dut (
    .clk_i(clk), .rst_i(rst),
    .e_alu_result_i(in_view.alu_result), .e_csr_wdata_i(in_view.csr_wdata),
    .e_src2_i(in_view.src2), .e_rd_i(in_view.rd),
    .e_wenReg_i(in_view.wen_reg), .e_wenCsr_i(in_view.wen_csr),
    .e_wenMem_i(in_view.wen_mem), .e_renMem_i(in_view.ren_mem),
    .e_is_load_signed_i(in_view.is_load_signed), .e_mask_i(in_view.mask),
    .e_sys_info_i(in_view.sys_info), .e_valid_i(tb_if.valid),
    .M_ready_o(tb_if.ready),
    .m_alu_result_o(m_alu), .m_csr_wdata_o(m_csr), .m_src2_o(m_src2),
    .m_rd_o(m_rd), .m_wenReg_o(m_wen_reg), .m_wenCsr_o(m_wen_csr),
    .m_wenMem_o(m_wen_mem), .m_renMem_o(m_ren_mem),
    .m_is_load_signed_o(m_lsig), .m_mask_o(m_mask), .m_sys_info_o(m_sys),
    .M_valid_o(m_valid), .m_ready_i(m_ready), .flush_i(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: FIFO of in-flight bundles plus the bundle currently shown.
  ex_mem_bundle_t q[$];
  ex_mem_bundle_t shown;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_mem_bundle_t rnd_bundle();
    ex_mem_bundle_t b;
    b.alu_result     = $urandom();
    b.csr_wdata      = $urandom();
    b.src2           = $urandom();
    b.rd             = 5'($urandom_range(31));
    b.wen_reg        = 1'($urandom_range(1));
    b.wen_csr        = 1'($urandom_range(1));
    b.wen_mem        = 1'($urandom_range(1));
    b.ren_mem        = 1'($urandom_range(1));
    b.is_load_signed = 1'($urandom_range(1));
    b.mask           = 8'($urandom_range(255));
    b.sys_info       = 4'($urandom_range(15));
    return b;
  endfunction

  // Model update at each rising edge from the inputs held during the cycle.
  initial begin
    bit acc, del;
    shown = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        shown = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        acc = tb_if.valid && (q.size() < 2);
        del = (q.size() > 0) && m_ready;
        if (del) void'(q.pop_front());
        if (acc) q.push_back(in_view);
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    ex_mem_bundle_t act, exp;
    logic vexp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vexp = (q.size() != 0);
        act.alu_result = m_alu;      act.csr_wdata = m_csr;
        act.src2 = m_src2;           act.rd = m_rd;
        act.wen_reg = m_wen_reg;     act.wen_csr = m_wen_csr;
        act.wen_mem = m_wen_mem;     act.ren_mem = m_ren_mem;
        act.is_load_signed = m_lsig; act.mask = m_mask;
        act.sys_info = m_sys;
        exp = shown;
        exp.wen_reg = shown.wen_reg & vexp;
        exp.wen_csr = shown.wen_csr & vexp;
        exp.wen_mem = shown.wen_mem & vexp;
        exp.ren_mem = shown.ren_mem & vexp;
        chk("model_valid", 128'(m_valid), 128'(vexp));
        chk("model_ready", 128'(tb_if.ready), 128'(q.size() < 2));
        chk("model_bundle", 128'(act), 128'(exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] alu, input logic wen);
    ex_mem_bundle_t b;
    b = rnd_bundle();
    b.alu_result = alu;
    b.wen_reg = wen;
    tb_if.data = b;
    tb_if.valid = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    tb_if.valid = 1'b0;
    tb_if.data = '0;

    // Reset held two cycles
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_valid", 128'(m_valid), 128'(1'b0));
    chk("rst_ready", 128'(tb_if.ready), 128'(1'b1));
    chk("rst_alu", 128'(m_alu), 128'(32'h0));
    rst = 1'b0;

    // Streaming
    m_ready = 1'b1;
    send(32'h10, 1'b0); tick();
    chk("stream_10", 128'(m_alu), 128'(32'h10));
    chk("stream_rdy1", 128'(tb_if.ready), 128'(1'b1));
    send(32'h20, 1'b0); tick();
    chk("stream_20", 128'(m_alu), 128'(32'h20));
    chk("stream_rdy2", 128'(tb_if.ready), 128'(1'b1));
    send(32'h30, 1'b0); tick();
    chk("stream_30", 128'(m_alu), 128'(32'h30));
    tb_if.valid = 1'b0; tick();
    chk("stream_drain", 128'(m_valid), 128'(1'b0));

    // Backpressure
    m_ready = 1'b0;
    send(32'hA, 1'b0); tick();
    send(32'hB, 1'b0); tick();
    chk("bp_ready0", 128'(tb_if.ready), 128'(1'b0));
    chk("bp_hold_a", 128'(m_alu), 128'(32'hA));
    tb_if.valid = 1'b0; tick();
    chk("bp_still_a", 128'(m_alu), 128'(32'hA));
    m_ready = 1'b1; tick();
    chk("bp_out_b", 128'(m_alu), 128'(32'hB));
    chk("bp_ready1", 128'(tb_if.ready), 128'(1'b1));
    tick();
    chk("bp_empty", 128'(m_valid), 128'(1'b0));

    // Simultaneous accept and deliver in ONE
    m_ready = 1'b0;
    send(32'h1, 1'b0); tick();
    m_ready = 1'b1;
    send(32'h2, 1'b0); tick();
    chk("sim_alu2", 128'(m_alu), 128'(32'h2));
    chk("sim_one", 128'({m_valid, tb_if.ready}), 128'(2'b11));
    tb_if.valid = 1'b0; tick();

    // Flush from TWO
    m_ready = 1'b0;
    send(32'h5, 1'b1); tick();
    send(32'h6, 1'b1); tick();
    chk("fl_two", 128'({m_valid, tb_if.ready, m_wen_reg}), 128'(3'b101));
    tb_if.valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("fl_valid", 128'(m_valid), 128'(1'b0));
    chk("fl_wenreg", 128'(m_wen_reg), 128'(1'b0));
    chk("fl_ready", 128'(tb_if.ready), 128'(1'b1));

    // Reset has priority over flush and drops a pending accept
    send(32'h7, 1'b1); tick();
    tb_if.valid = 1'b0;
    rst = 1'b1; flush = 1'b1; m_ready = 1'b1;
    send(32'h99, 1'b1); tick();
    rst = 1'b0; flush = 1'b0; tb_if.valid = 1'b0;
    chk("rp_valid", 128'(m_valid), 128'(1'b0));
    chk("rp_ready", 128'(tb_if.ready), 128'(1'b1));
    chk("rp_alu", 128'(m_alu), 128'(32'h0));
    tick(); tick();
    chk("rp_no_deliver", 128'(m_valid), 128'(1'b0));

    // Randomized traffic with varying backpressure, flushes and resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(79) == 0);
      flush = ($urandom_range(19) == 0);
      tb_if.valid = 1'($urandom_range(1));
      tb_if.data = rnd_bundle();
      if (i < 200) m_ready = ($urandom_range(3) != 0);
      else if (i < 400) m_ready = ($urandom_range(3) == 0);
      else m_ready = 1'($urandom_range(1));
      tick();
    end
    rst = 1'b0; flush = 1'b0; tb_if.valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
